dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between two requesters: port 0 = pipeline MEM stage,
//  port 1 = secondary master (loader/DMA/debug). Arbitrates per cycle, drives the memory's
//  address/write_data/mem_write/mem_read, and returns registered read data with a valid
//  strobe. Port 0 has priority; a wait counter prevents port-1 starvation.
// PARAMETERS
//  AW        10  word-address width (1024-word data memory)
//  DW        32  data width
//  MAX_WAIT  4   consecutive denied port-1 cycles before port 1 is forced to win (>=1)
// PORTS
//  clk            in   1   single clock, all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  p0_req/p1_req  in   1   access request; hold req/we/addr/wdata stable until gnt
//  p0_we/p1_we    in   1   1 = write, 0 = read
//  p0_addr/p1_addr in  AW  word address
//  p0_wdata/p1_wdata in DW write data
//  p0_gnt/p1_gnt  out  1   combinational grant; access happens this cycle
//  p0_rvalid/p1_rvalid out 1 read data valid (one cycle after granted read)
//  p0_rdata/p1_rdata out DW registered read data, holds until next granted read of that port
//  mem_address    out  32  to memory; {zeros, winner addr}
//  mem_write_data out  DW  winner wdata
//  mem_write      out  1   winner req & we
//  mem_read       out  1   winner req & ~we
//  mem_read_data  in   DW  combinational memory read data
//  stall_p0       out  1   p0_req & ~p0_gnt (pipeline freeze request)
// BEHAVIOUR
//  - Reset (rst_n low, async): wait_cnt=0, rvalid both 0, rdata both 0, state=IDLE;
//    p0_gnt/p1_gnt/mem_write/mem_read forced 0 while rst_n low.
//  - States: IDLE (no port won last cycle), OWN0 (p0 won), OWN1 (p1 won); registered
//    each edge from the winner, used only for reporting and wait_cnt clearing.
//  - Winner: only p0_req -> p0; only p1_req -> p1; both -> p1 if wait_cnt==MAX_WAIT, else p0.
//  - wait_cnt (width clog2(MAX_WAIT+1)): +1 when p1_req & ~p1_gnt, saturates at MAX_WAIT;
//    cleared to 0 on p1_gnt or when p1_req low.
//  - Exactly one gnt at most per cycle; mem_write and mem_read never both 1.
//  - No winner: mem_write=mem_read=0, mem_address/mem_write_data = p0 values (don't-care).
//  - Read latency: granted read in cycle N -> pX_rdata <= mem_read_data at edge ending N,
//    pX_rvalid=1 for cycle N+1 only. Back-to-back reads give rvalid every cycle.
//  - Writes: memory commits at the edge ending the grant cycle; no response strobe.
//  - Read-after-write same address, consecutive grants: read in N+1 sees data written in N.
//  - Reset asserted mid-access: pending rvalid dropped, no memory access issued during reset;
//    requesters must re-issue after reset.
//  - Address bits above AW of mem_address are driven 0.
// CONFIGURATION
//  DMEM_ARB_STATS_EN defined: adds outputs conflict_cnt (32) = cycles with p0_req&p1_req,
//    and force_cnt (32) = cycles p1 won via starvation rule; both reset 0, wrap at 2^32.
//  Not defined: ports and counters absent; arbitration identical.
// TESTING
//  1. p0 read addr 5 (mem[5]=0xDEADBEEF), p1 idle -> p0_gnt same cycle, p0_rvalid next
//     cycle, p0_rdata=0xDEADBEEF, stall_p0=0.
//  2. p0 and p1 both request continuously (MAX_WAIT=4) -> p0 granted 4 cycles, p1 granted
//     on 5th, pattern repeats; p1 never waits more than 4 cycles; stall_p0=1 on p1 cycles.
//  3. p1 write 0x12345678 to addr 3, then p0 read addr 3 next cycle -> p0_rdata=0x12345678.
//  4. p0 write and p1 read same cycle, wait_cnt=0 -> only p0_gnt, mem_write=1, mem_read=0;
//     p1 read granted next cycle with post-write data.
//  5. rst_n low during granted p1 read -> p1_rvalid 0, p1_rdata 0, no gnt until release;
//     first cycle after release arbitrates normally with wait_cnt=0.
//  6. DMEM_ARB_STATS_EN: run scenario 2 for 10 cycles -> conflict_cnt=10, force_cnt=2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: port 0 (pipeline) has priority and port 1
// is guaranteed service after MaxWait denials. Define DMEM_ARB_STATS_EN for conflict/force counters.
module dmem_arbiter #(
  parameter int unsigned Aw      = 10,
  parameter int unsigned Dw      = 32,
  parameter int unsigned MaxWait = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          p0_req_i,
  input  logic          p0_we_i,
  input  logic [Aw-1:0] p0_addr_i,
  input  logic [Dw-1:0] p0_wdata_i,
  input  logic          p1_req_i,
  input  logic          p1_we_i,
  input  logic [Aw-1:0] p1_addr_i,
  input  logic [Dw-1:0] p1_wdata_i,
  output logic          p0_gnt_o,
  output logic          p1_gnt_o,
  output logic          p0_rvalid_o,
  output logic          p1_rvalid_o,
  output logic [Dw-1:0] p0_rdata_o,
  output logic [Dw-1:0] p1_rdata_o,
  output logic [31:0]   mem_address_o,
  output logic [Dw-1:0] mem_write_data_o,
  output logic          mem_write_o,
  output logic          mem_read_o,
  input  logic [Dw-1:0] mem_read_data_i,
  output logic          stall_p0_o
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]   conflict_cnt_o,
  output logic [31:0]   force_cnt_o
`endif
);

  localparam int unsigned WaitW = $clog2(MaxWait + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            state_q, state_d;
  logic [WaitW-1:0]  wait_q, wait_d, wait_base;
  logic              p0_win, p1_win, p0_gnt, p1_gnt, win_we;
  logic              p0_rvalid_q, p1_rvalid_q, p0_rd, p1_rd;
  logic [Dw-1:0]     p0_rdata_q, p1_rdata_q;

  always_comb begin
    p1_win  = p1_req_i & (~p0_req_i | (wait_q == WaitMax));
    p0_win  = p0_req_i & ~p1_win;
    // No access may reach the memory while reset is held.
    p0_gnt  = p0_win & rst_ni;
    p1_gnt  = p1_win & rst_ni;
    win_we  = p1_win ? p1_we_i : p0_we_i;
    p0_rd   = p0_gnt & ~p0_we_i;
    p1_rd   = p1_gnt & ~p1_we_i;

    state_d = StIdle;
    if (p1_gnt) begin
      state_d = StOwn1;
    end else if (p0_gnt) begin
      state_d = StOwn0;
    end

    // A port-1 win last cycle always leaves the count at zero.
    wait_base = (state_q == StOwn1) ? '0 : wait_q;
    wait_d    = '0;
    if (p1_req_i && !p1_gnt) begin
      wait_d = (wait_base == WaitMax) ? WaitMax : wait_base + WaitW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      p0_rvalid_q <= 1'b0;
      p1_rvalid_q <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      p0_rvalid_q <= p0_rd;
      p1_rvalid_q <= p1_rd;
      if (p0_rd) p0_rdata_q <= mem_read_data_i;
      if (p1_rd) p1_rdata_q <= mem_read_data_i;
    end
  end

  assign p0_gnt_o         = p0_gnt;
  assign p1_gnt_o         = p1_gnt;
  assign p0_rvalid_o      = p0_rvalid_q;
  assign p1_rvalid_o      = p1_rvalid_q;
  assign p0_rdata_o       = p0_rdata_q;
  assign p1_rdata_o       = p1_rdata_q;
  assign mem_address_o    = {{(32 - Aw){1'b0}}, (p1_win ? p1_addr_i : p0_addr_i)};
  assign mem_write_data_o = p1_win ? p1_wdata_i : p0_wdata_i;
  assign mem_write_o      = (p0_gnt | p1_gnt) & win_we;
  assign mem_read_o       = (p0_gnt | p1_gnt) & ~win_we;
  assign stall_p0_o       = p0_req_i & ~p0_gnt;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] conflict_cnt_q, force_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_cnt_q <= '0;
      force_cnt_q    <= '0;
    end else begin
      if (p0_req_i && p1_req_i) conflict_cnt_q <= conflict_cnt_q + 32'd1;
      // Port 1 only beats a live port-0 request through the starvation rule.
      if (p1_gnt && p0_req_i) force_cnt_q <= force_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
  assign force_cnt_o    = force_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter against a transaction-level model with its own memory copy.
module tb_dmem_arbiter;
  localparam int unsigned Aw = 10;
  localparam int unsigned Dw = 32;
  localparam int unsigned MaxWait = 4;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [Aw-1:0] p0_addr = '0, p1_addr = '0;
  logic [Dw-1:0] p0_wdata = '0, p1_wdata = '0;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_write, mem_read, stall_p0;
  logic [Dw-1:0] p0_rdata, p1_rdata, mem_write_data, mem_read_data;
  logic [31:0]   mem_address;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0]   conflict_cnt, force_cnt;
`endif

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.Aw(Aw), .Dw(Dw), .MaxWait(MaxWait)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .p0_req_i        (p0_req),
    .p0_we_i         (p0_we),
    .p0_addr_i       (p0_addr),
    .p0_wdata_i      (p0_wdata),
    .p1_req_i        (p1_req),
    .p1_we_i         (p1_we),
    .p1_addr_i       (p1_addr),
    .p1_wdata_i      (p1_wdata),
    .p0_gnt_o        (p0_gnt),
    .p1_gnt_o        (p1_gnt),
    .p0_rvalid_o     (p0_rvalid),
    .p1_rvalid_o     (p1_rvalid),
    .p0_rdata_o      (p0_rdata),
    .p1_rdata_o      (p1_rdata),
    .mem_address_o   (mem_address),
    .mem_write_data_o(mem_write_data),
    .mem_write_o     (mem_write),
    .mem_read_o      (mem_read),
    .mem_read_data_i (mem_read_data),
    .stall_p0_o      (stall_p0)
`ifdef DMEM_ARB_STATS_EN
    ,
    .conflict_cnt_o  (conflict_cnt),
    .force_cnt_o     (force_cnt)
`endif
  );

  // Data memory seen by the DUT: combinational read, write at the clock edge.
  logic        clr = 1'b1;
  logic [31:0] env_mem [1024];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) env_mem[i] <= '0;
    end else if (mem_write) begin
      env_mem[mem_address[9:0]] <= mem_write_data;
    end
  end
  assign mem_read_data = env_mem[mem_address[9:0]];

  // Reference model state
  logic [31:0] mmem [1024];
  int          streak;
  bit          erv0, erv1, obs_p1_gnt;
  logic [31:0] erd0, erd1, m_conf, m_force;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    streak = 0; erv0 = 0; erv1 = 0; erd0 = '0; erd1 = '0; m_conf = '0; m_force = '0;
  endtask

  task automatic drv0(input bit we, input logic [Aw-1:0] a, input logic [Dw-1:0] d);
    p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drv1(input bit we, input logic [Aw-1:0] a, input logic [Dw-1:0] d);
    p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  task automatic new_reqs();
    if (!p0_req && $urandom_range(0, 99) < 60) drv0(1'($urandom_range(0, 1)),
        Aw'($urandom_range(0, 15)), $urandom);
    if (!p1_req && $urandom_range(0, 99) < 60) drv1(1'($urandom_range(0, 1)),
        Aw'($urandom_range(0, 15)), $urandom);
  endtask

  // Called at posedge+1 with inputs stable; checks at the negedge, advances one cycle.
  task automatic cycle();
    bit          w0, w1;
    logic [31:0] ea;
    @(negedge clk);
    w1 = p1_req && (!p0_req || streak >= MaxWait);
    w0 = p0_req && !w1;
    check("p0_gnt", 32'(p0_gnt), 32'(w0));
    check("p1_gnt", 32'(p1_gnt), 32'(w1));
    check("stall_p0", 32'(stall_p0), 32'(p0_req && !w0));
    check("mem_write", 32'(mem_write), 32'((w0 && p0_we) || (w1 && p1_we)));
    check("mem_read", 32'(mem_read), 32'((w0 && !p0_we) || (w1 && !p1_we)));
    if (w0 || w1) begin
      ea = {22'b0, (w1 ? p1_addr : p0_addr)};
      check("mem_address", mem_address, ea);
      if ((w0 && p0_we) || (w1 && p1_we))
        check("mem_wdata", mem_write_data, w1 ? p1_wdata : p0_wdata);
    end
    check("p0_rvalid", 32'(p0_rvalid), 32'(erv0));
    check("p1_rvalid", 32'(p1_rvalid), 32'(erv1));
    check("p0_rdata", p0_rdata, erd0);
    check("p1_rdata", p1_rdata, erd1);
    obs_p1_gnt = p1_gnt;
    erv0 = w0 && !p0_we;
    erv1 = w1 && !p1_we;
    if (erv0) erd0 = mmem[p0_addr];
    if (erv1) erd1 = mmem[p1_addr];
    if (w0 && p0_we) mmem[p0_addr] = p0_wdata;
    if (w1 && p1_we) mmem[p1_addr] = p1_wdata;
    if (p0_req && p1_req) m_conf = m_conf + 32'd1;
    if (w1 && p0_req) m_force = m_force + 32'd1;
    streak = (p1_req && !w1) ? ((streak < MaxWait) ? streak + 1 : MaxWait) : 0;
    @(posedge clk);
    #1;
    if (w0) p0_req = 1'b0;
    if (w1) p1_req = 1'b0;
  endtask

  initial begin
    int n1;
    for (int i = 0; i < 1024; i++) mmem[i] = '0;
    model_reset();

    // Reset: requests are ignored and outputs are cleared
    drv0(1'b0, 10'd1, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
    check("rst_p0_rdata", p0_rdata, 32'd0);
    p0_req = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    clr = 1'b0;

    // Both ports requesting continuously: p1 wins every fifth cycle
    n1 = 0;
    for (int c = 0; c < 10; c++) begin
      drv0(1'b0, Aw'(c), '0);
      drv1(1'b0, Aw'(c + 20), '0);
      cycle();
      if (obs_p1_gnt) n1++;
      if (c == 4 || c == 9) check("s2_p1_forced", 32'(obs_p1_gnt), 32'd1);
    end
    check("s2_p1_grants", 32'(n1), 32'd2);
`ifdef DMEM_ARB_STATS_EN
    check("s6_conflict", conflict_cnt, 32'd10);
    check("s6_force", force_cnt, 32'd2);
`endif
    p0_req = 1'b0;
    p1_req = 1'b0;
    cycle();

    // p0 read of a location written by p1
    drv1(1'b1, 10'd5, 32'hDEADBEEF);
    cycle();
    drv0(1'b0, 10'd5, '0);
    cycle();
    cycle();
    check("s1_p0_rdata", p0_rdata, 32'hDEADBEEF);

    // Read immediately after write, same address
    drv1(1'b1, 10'd3, 32'h12345678);
    cycle();
    drv0(1'b0, 10'd3, '0);
    cycle();
    cycle();
    check("s3_p0_rdata", p0_rdata, 32'h12345678);

    // Simultaneous p0 write / p1 read: p1 follows and sees the new data
    drv0(1'b1, 10'd9, 32'hCAFEF00D);
    drv1(1'b0, 10'd9, '0);
    cycle();
    cycle();
    cycle();
    check("s4_p1_rdata", p1_rdata, 32'hCAFEF00D);

    repeat (1500) begin
      new_reqs();
      cycle();
    end

    // Reset during a granted p1 read
    p0_req = 1'b0;
    drv1(1'b0, 10'd9, '0);
    @(negedge clk);
    check("s5_pre_gnt", 32'(p1_gnt), 32'(!p0_req));
    rst_ni = 1'b0;
    #1;
    check("s5_gnt", 32'(p1_gnt), 32'd0);
    check("s5_mem_read", 32'(mem_read), 32'd0);
    check("s5_rdata", p1_rdata, 32'd0);
    @(posedge clk);
    #1;
    check("s5_rvalid", 32'(p1_rvalid), 32'd0);
    rst_ni = 1'b1;
    model_reset();
    drv0(1'b0, 10'd9, '0);
    cycle();

    repeat (300) begin
      new_reqs();
      cycle();
    end
`ifdef DMEM_ARB_STATS_EN
    check("conflict_cnt", conflict_cnt, m_conf);
    check("force_cnt", force_cnt, m_force);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
